// File: rtl/cam_pixel_writer.sv
// cam_pixel_writer
// Packs an 8-bit RGB565 camera byte stream (high byte first) into 16-bit
// pixels and writes them into a downstream FIFO on the camera pixel clock.
// Frames are delimited by i_vsync; lines by i_href.
//
// Optional feature: define CAM_WRITER_DROP_FRAME_EN to abandon the rest of a
// frame after the first FIFO overflow (FSM moves to DROP until the next
// i_vsync rise, and o_eof is suppressed for that frame). Without the macro
// only the colliding pixel is lost and DROP is never entered.
//
// Handshake: the FIFO has no ready; o_wr is a one-cycle write strobe that is
// only raised when i_wfull was low on the cycle the pixel completed. A pixel
// completing while i_wfull is high is lost and o_overflow latches until reset.
module cam_pixel_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_wclk,
  input  logic        i_rrstn,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_cam_data,
  input  logic        i_wfull,
  output logic        o_wr,
  output logic [15:0] o_wdata,
  output logic        o_sof,
  output logic        o_eof,
  output logic [10:0] o_xcnt,
  output logic [9:0]  o_ycnt,
  output logic        o_overflow,
  output logic        o_short_frame,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  Y_END  = 10'(V_ACTIVE);

  state_t      state;
  logic        vsync_q;
  logic        href_q;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [10:0] x;
  logic [9:0]  y;
  logic        line_done;
  logic        sof_pending;

  logic        vsync_rise;
  logic        vsync_fall;
  logic        href_rise;
  logic        href_fall;
  logic [10:0] x_eff;
  logic        line_done_eff;
  logic        byte_ok;
  logic        last_col;
  logic        last_row;

  // Edge detection against the previous-cycle sync levels.
  assign vsync_rise = i_vsync & ~vsync_q;
  assign vsync_fall = ~i_vsync & vsync_q;
  assign href_rise  = i_href & ~href_q;
  assign href_fall  = ~i_href & href_q;

  // A new href pulse restarts the column before its first byte is counted.
  assign x_eff         = href_rise ? 11'd0 : x;
  assign line_done_eff = href_rise ? 1'b0 : line_done;

  // A byte is accepted only inside a line that has not yet delivered H_ACTIVE
  // pixels and only while the frame still has lines to fill.
  assign byte_ok  = i_href & ~line_done_eff & (y < Y_END);
  assign last_col = (x_eff == X_LAST);
  assign last_row = (y == Y_LAST);

  assign o_ycnt  = y;
  assign o_state = state;

  // Frame/line FSM, pixel packing, counters and registered FIFO outputs.
  always_ff @(posedge i_wclk or negedge i_rrstn) begin
    if (!i_rrstn) begin
      state         <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase         <= 1'b0;
      hi_byte       <= 8'd0;
      x             <= 11'd0;
      y             <= 10'd0;
      line_done     <= 1'b0;
      sof_pending   <= 1'b0;
      o_wr          <= 1'b0;
      o_wdata       <= 16'd0;
      o_sof         <= 1'b0;
      o_eof         <= 1'b0;
      o_xcnt        <= 11'd0;
      o_overflow    <= 1'b0;
      o_short_frame <= 1'b0;
    end else begin
      vsync_q       <= i_vsync;
      href_q        <= i_href;
      o_wr          <= 1'b0;
      o_sof         <= 1'b0;
      o_eof         <= 1'b0;
      o_short_frame <= 1'b0;

      case (state)
        IDLE: begin
          // Never capture the tail of a frame already running at reset release.
          if (i_vsync) state <= WAIT_SOF;
        end

        WAIT_SOF: begin
          if (vsync_fall) begin
            state       <= ACTIVE;
            x           <= 11'd0;
            y           <= 10'd0;
            phase       <= 1'b0;
            line_done   <= 1'b0;
            sof_pending <= 1'b1;
          end
        end

        ACTIVE, DROP: begin
          if (vsync_rise) begin
            // New frame sync wins over anything on the byte stream this cycle.
            if (y < Y_END) o_short_frame <= 1'b1;
            state <= WAIT_SOF;
            phase <= 1'b0;
          end else begin
            if (href_rise) begin
              x         <= 11'd0;
              line_done <= 1'b0;
            end
            // An odd trailing byte is dropped when the line ends.
            if (href_fall) phase <= 1'b0;

            if (byte_ok) begin
              if (!phase) begin
                hi_byte <= i_cam_data;
                phase   <= 1'b1;
              end else begin
                phase  <= 1'b0;
                o_xcnt <= x_eff;
                if (last_col) begin
                  x         <= 11'd0;
                  y         <= y + 10'd1;
                  line_done <= 1'b1;
                end else begin
                  x <= x_eff + 11'd1;
                end

                if (state == ACTIVE) begin
                  if (i_wfull) begin
                    o_overflow <= 1'b1;
`ifdef CAM_WRITER_DROP_FRAME_EN
                    state <= DROP;
`endif
                  end else begin
                    o_wr        <= 1'b1;
                    o_wdata     <= {hi_byte, i_cam_data};
                    o_sof       <= sof_pending;
                    sof_pending <= 1'b0;
                  end

                  if (last_col && last_row) begin
`ifdef CAM_WRITER_DROP_FRAME_EN
                    if (!i_wfull) begin
                      o_eof <= 1'b1;
                      state <= WAIT_SOF;
                    end
`else
                    o_eof <= 1'b1;
                    state <= WAIT_SOF;
`endif
                  end
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_writer.sv
// Testbench for cam_pixel_writer (H_ACTIVE=4, V_ACTIVE=2).
// The reference model works on whole lines of bytes: it decides which pixels
// reach the FIFO, which frames end in o_eof and which are cut short, and
// queues the expected {sof, wdata} words for the scoreboard.
module tb_cam_pixel_writer;

  localparam int H_A = 4;
  localparam int V_A = 2;

  logic        i_wclk;
  logic        i_rrstn;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_cam_data;
  logic        i_wfull;
  logic        o_wr;
  logic [15:0] o_wdata;
  logic        o_sof;
  logic        o_eof;
  logic [10:0] o_xcnt;
  logic [9:0]  o_ycnt;
  logic        o_overflow;
  logic        o_short_frame;
  logic [1:0]  o_state;

  cam_pixel_writer #(.H_ACTIVE(H_A), .V_ACTIVE(V_A)) dut (
    .i_wclk        (i_wclk),
    .i_rrstn       (i_rrstn),
    .i_vsync       (i_vsync),
    .i_href        (i_href),
    .i_cam_data    (i_cam_data),
    .i_wfull       (i_wfull),
    .o_wr          (o_wr),
    .o_wdata       (o_wdata),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_xcnt        (o_xcnt),
    .o_ycnt        (o_ycnt),
    .o_overflow    (o_overflow),
    .o_short_frame (o_short_frame),
    .o_state       (o_state)
  );

  // ---------------- clock / reset ----------------
  initial i_wclk = 1'b0;
  always #5 i_wclk = ~i_wclk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int got_eof = 0;
  int got_short = 0;
  int exp_eof = 0;
  int exp_short = 0;

  logic [16:0] exp_q[$];

  // model state
  bit       m_seen_high = 0;
  bit       m_cap = 0;
  bit       m_drop = 0;
  bit       m_sof_pend = 0;
  bit       m_ovf = 0;
  int       m_lines = 0;
  logic [7:0] m_hi = 8'd0;
  logic [7:0] seq_byte = 8'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_wclk) begin
    if (i_rrstn) begin
      if (o_wr) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          check("wr_word", {15'd0, o_sof, o_wdata}, {15'd0, exp_q.pop_front()});
        end
      end else if (o_sof) begin
        check("sof_without_wr", {31'd0, o_wr}, 32'd1);
      end
      if (o_eof) got_eof++;
      if (o_short_frame) got_short++;
    end
  end

  // ---------------- model events ----------------
  task automatic model_vsync_rise();
    if (m_cap) exp_short++;
    m_cap = 0;
    m_seen_high = 1;
  endtask

  task automatic model_vsync_fall();
    if (m_seen_high) begin
      m_cap = 1;
      m_drop = 0;
      m_lines = 0;
      m_sof_pend = 1;
    end
  endtask

  task automatic model_byte(input int i, input logic [7:0] b, input logic full);
    if (m_cap && (i / 2) < H_A) begin
      if (i % 2 == 0) begin
        m_hi = b;
      end else begin
        if (!m_drop) begin
          if (full) begin
            m_ovf = 1;
`ifdef CAM_WRITER_DROP_FRAME_EN
            m_drop = 1;
`endif
          end else begin
            exp_q.push_back({m_sof_pend, m_hi, b});
            m_sof_pend = 0;
          end
        end
        if ((i / 2) == H_A - 1) begin
          m_lines++;
          if (m_lines == V_A) begin
            if (!m_drop) exp_eof++;
            m_cap = 0;
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input int i, input int full_pix, input int pct, input bit seq);
    logic [7:0] b;
    logic       full;
    b = seq ? seq_byte : 8'($urandom_range(0, 255));
    if (seq) seq_byte = seq_byte + 8'd1;
    if (i % 2 == 1) full = ((i / 2) == full_pix) || (int'($urandom_range(0, 99)) < pct);
    else            full = (pct > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge i_wclk);
    i_href = 1'b1;
    i_cam_data = b;
    i_wfull = full;
    model_byte(i, b, full);
  endtask

  task automatic drive_line(input int nb, input int full_pix, input int pct, input bit seq);
    for (int i = 0; i < nb; i++) send_byte(i, full_pix, pct, seq);
    @(negedge i_wclk);
    i_href = 1'b0;
    i_wfull = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge i_wclk);
  endtask

  task automatic vsync_pulse();
    @(negedge i_wclk);
    i_vsync = 1'b1;
    model_vsync_rise();
    repeat ($urandom_range(2, 4)) @(negedge i_wclk);
    i_vsync = 1'b0;
    model_vsync_fall();
    repeat (2) @(negedge i_wclk);
  endtask

  // Last (pixel-completing) byte arrives on the same cycle as the vsync rise.
  task automatic drive_line_abort(input int nb);
    for (int i = 0; i < nb - 1; i++) send_byte(i, -1, 0, 0);
    @(negedge i_wclk);
    i_href = 1'b1;
    i_cam_data = 8'($urandom_range(0, 255));
    i_wfull = 1'b0;
    i_vsync = 1'b1;
    model_vsync_rise();
    @(negedge i_wclk);
    i_href = 1'b0;
    repeat (2) @(negedge i_wclk);
    i_vsync = 1'b0;
    model_vsync_fall();
    repeat (2) @(negedge i_wclk);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (4) @(negedge i_wclk);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_eof"}, 32'(got_eof), 32'(exp_eof));
    check({tag, "_short"}, 32'(got_short), 32'(exp_short));
    check({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, m_ovf});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rrstn = 1'b0;
    i_vsync = 1'b0;
    i_href = 1'b0;
    i_cam_data = 8'd0;
    i_wfull = 1'b0;
    repeat (3) @(negedge i_wclk);
    check("rst_wr", {31'd0, o_wr}, 32'd0);
    check("rst_wdata", {16'd0, o_wdata}, 32'd0);
    check("rst_sof", {31'd0, o_sof}, 32'd0);
    check("rst_eof", {31'd0, o_eof}, 32'd0);
    check("rst_short", {31'd0, o_short_frame}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check("rst_xcnt", {21'd0, o_xcnt}, 32'd0);
    check("rst_ycnt", {22'd0, o_ycnt}, 32'd0);
    i_rrstn = 1'b1;
    repeat (3) @(negedge i_wclk);

    // Clean frame with bytes 0x01..0x10.
    vsync_pulse();
    seq_byte = 8'd1;
    drive_line(2 * H_A, -1, 0, 1);
    drive_line(2 * H_A, -1, 0, 1);
    settle_and_check("clean");
    check("clean_xcnt", {21'd0, o_xcnt}, 32'(H_A - 1));
    check("clean_ycnt", {22'd0, o_ycnt}, 32'(V_A));

    // Same frame, FIFO full during pixel 3 only.
    vsync_pulse();
    seq_byte = 8'd1;
    drive_line(2 * H_A, 2, 0, 1);
    drive_line(2 * H_A, -1, 0, 1);
    settle_and_check("full_p3");

    // Odd-length line, then two full lines.
    vsync_pulse();
    drive_line(7, -1, 0, 0);
    drive_line(2 * H_A, -1, 0, 0);
    drive_line(2 * H_A, -1, 0, 0);
    settle_and_check("odd_line");

    // Frame cut short after line 0, next frame normal.
    vsync_pulse();
    drive_line(2 * H_A, -1, 0, 0);
    vsync_pulse();
    drive_line(2 * H_A, -1, 0, 0);
    drive_line(2 * H_A, -1, 0, 0);
    settle_and_check("short");

    // Pixel completion colliding with the vsync rise.
    vsync_pulse();
    drive_line(2 * H_A, -1, 0, 0);
    drive_line_abort(2 * H_A);
    drive_line(2 * H_A, -1, 0, 0);
    drive_line(2 * H_A, -1, 0, 0);
    settle_and_check("collide");

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      vsync_pulse();
      for (int l = 0, nl = $urandom_range(1, 3); l < nl; l++) begin
        drive_line(($urandom_range(0, 1) == 1) ? 2 * H_A : $urandom_range(1, 10), -1, 20, 0);
      end
    end
    vsync_pulse();
    settle_and_check("random");

    // Reset asserted while a write is on the outputs.
    vsync_pulse();
    @(negedge i_wclk);
    i_href = 1'b1;
    i_cam_data = 8'hA5;
    @(negedge i_wclk);
    i_cam_data = 8'h5A;
    @(posedge i_wclk);
    #1;
    check("pre_rst_wr", {31'd0, o_wr}, 32'd1);
    i_rrstn = 1'b0;
    #1;
    check("mid_rst_wr", {31'd0, o_wr}, 32'd0);
    check("mid_rst_wdata", {16'd0, o_wdata}, 32'd0);
    check("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
    check("mid_rst_ycnt", {22'd0, o_ycnt}, 32'd0);
    exp_q.delete();
    m_cap = 0;
    m_seen_high = 0;
    m_ovf = 0;
    @(negedge i_wclk);
    repeat (2) @(negedge i_wclk);

    // Release mid-line with vsync low: nothing may be written.
    i_rrstn = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(i, -1, 0, 0);
    @(negedge i_wclk);
    i_href = 1'b0;
    repeat (2) @(negedge i_wclk);
    drive_line(2 * H_A, -1, 0, 0);
    drive_line(2 * H_A, -1, 0, 0);
    settle_and_check("post_rst_idle");

    vsync_pulse();
    drive_line(2 * H_A, -1, 0, 0);
    drive_line(2 * H_A, -1, 0, 0);
    settle_and_check("post_rst_frame");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
